// File: rtl/mem_access_stage.sv
// M-stage memory access: issues one registered request per load/store, stalls
// upstream until ack or timeout, and feeds the write-back register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_validM,
  input  logic        i_reg_writeM,
  input  logic        i_mem_to_regM,
  input  logic        i_mem_writeM,
  input  logic [31:0] i_alu_outM,
  input  logic [31:0] i_write_dataM,
  input  logic [4:0]  i_write_regM,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic        o_reg_writeW,
  output logic        o_mem_to_regW,
  output logic [31:0] o_alu_outW,
  output logic [31:0] o_dm_outW,
  output logic [4:0]  o_write_regW,
  output logic        o_bus_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;
  logic [31:0]       dmReg, dmNext;
  logic [31:0]       addrNext, wdataNext;
  logic              memReqNext, memWeNext, busErrNext;
  logic              stall;
  logic              memop;

  assign memop = i_validM & (i_mem_to_regM | i_mem_writeM);

  // State and registered memory-side outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      waitCnt     <= '0;
      dmReg       <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      dmReg       <= dmNext;
      o_mem_req   <= memReqNext;
      o_mem_we    <= memWeNext;
      o_mem_addr  <= addrNext;
      o_mem_wdata <= wdataNext;
      o_bus_err   <= busErrNext;
    end
  end

  // Next-state, request control and stall
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    dmNext      = dmReg;
    memReqNext  = o_mem_req;
    memWeNext   = o_mem_we;
    addrNext    = o_mem_addr;
    wdataNext   = o_mem_wdata;
    busErrNext  = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall       = 1'b1;
          stateNext   = BUSY;
          memReqNext  = 1'b1;
          memWeNext   = i_mem_writeM;
          addrNext    = i_alu_outM;
          wdataNext   = i_write_dataM;
          waitCntNext = '0;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (i_mem_ack) begin
          if (!o_mem_we) dmNext = i_mem_rdata;
          memReqNext = 1'b0;
          stateNext  = DONE;
        end else if (waitCnt == LAST_CNT) begin
          // Abort: clear loaded data so a stale value is never written back
          dmNext     = '0;
          memReqNext = 1'b0;
          busErrNext = 1'b1;
          stateNext  = DONE;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign o_stall       = stall;
  assign o_reg_writeW  = i_reg_writeM & i_validM & ~stall;
  assign o_mem_to_regW = i_mem_to_regM & i_validM & ~stall;
  assign o_alu_outW    = i_alu_outM;
  assign o_write_regW  = i_write_regM;
  assign o_dm_outW     = dmReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model predicts stall/request
// timing from each op's ack delay and tracks the expected data register.
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 16;

  logic        clk, rstN;
  logic        validM, regWriteM, memToRegM, memWriteM;
  logic [31:0] aluOutM, writeDataM;
  logic [4:0]  writeRegM;
  logic        memReq, memWe, memAck, stall, regWriteW, memToRegW, busErr;
  logic [31:0] memAddr, memWdata, memRdata, aluOutW, dmOutW;
  logic [4:0]  writeRegW;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expDm = '0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_validM(validM), .i_reg_writeM(regWriteM),
    .i_mem_to_regM(memToRegM), .i_mem_writeM(memWriteM), .i_alu_outM(aluOutM),
    .i_write_dataM(writeDataM), .i_write_regM(writeRegM), .o_mem_req(memReq),
    .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_ack(memAck), .i_mem_rdata(memRdata), .o_stall(stall),
    .o_reg_writeW(regWriteW), .o_mem_to_regW(memToRegW), .o_alu_outW(aluOutW),
    .o_dm_outW(dmOutW), .o_write_regW(writeRegW), .o_bus_err(busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstN = 1'b0; validM = 0; regWriteM = 0; memToRegM = 0; memWriteM = 0;
    aluOutM = '0; writeDataM = '0; writeRegM = '0; memAck = 0; memRdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL reset memReq got=%b exp=0", memReq); end
    total++; if (memWe !== 1'b0) begin bad++; $display("FAIL reset memWe got=%b exp=0", memWe); end
    total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL reset memAddr got=%h exp=0", memAddr); end
    total++; if (memWdata !== 32'h0) begin bad++; $display("FAIL reset memWdata got=%h exp=0", memWdata); end
    total++; if (dmOutW !== 32'h0) begin bad++; $display("FAIL reset dmOutW got=%h exp=0", dmOutW); end
    total++; if (busErr !== 1'b0) begin bad++; $display("FAIL reset busErr got=%b exp=0", busErr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset stall got=%b exp=0", stall); end
    rstN = 1'b1;
    expDm = '0;
  endtask

  // One memory op; k = BUSY cycle (1-based) carrying the ack, k > TIMEOUT = never acked.
  task automatic run_op(input logic isLoad, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input logic regw, input int k,
                        input logic [31:0] rdata, input string tag);
    int   busyLen;
    logic timedOut;
    timedOut = (k > int'(TIMEOUT));
    busyLen  = timedOut ? int'(TIMEOUT) : k;
    validM = 1'b1; regWriteM = regw; memToRegM = isLoad; memWriteM = ~isLoad;
    aluOutM = addr; writeDataM = wdata; writeRegM = wreg;
    memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s idle stall got=%b exp=1", tag, stall); end
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL %s idle memReq got=%b exp=0", tag, memReq); end
    total++; if (regWriteW !== 1'b0) begin bad++; $display("FAIL %s idle regWriteW got=%b exp=0", tag, regWriteW); end
    total++; if (busErr !== 1'b0) begin bad++; $display("FAIL %s idle busErr got=%b exp=0", tag, busErr); end
    total++; if (aluOutW !== addr) begin bad++; $display("FAIL %s idle aluOutW got=%h exp=%h", tag, aluOutW, addr); end
    total++; if (dmOutW !== expDm) begin bad++; $display("FAIL %s idle dmOutW got=%h exp=%h", tag, dmOutW, expDm); end
    @(posedge clk); #1;
    for (int b = 1; b <= busyLen; b++) begin
      memAck = 1'(b == k);
      memRdata = (b == k) ? rdata : $urandom;
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s busy%0d stall got=%b exp=1", tag, b, stall); end
      total++; if (memReq !== 1'b1) begin bad++; $display("FAIL %s busy%0d memReq got=%b exp=1", tag, b, memReq); end
      total++; if (memWe !== ~isLoad) begin bad++; $display("FAIL %s busy%0d memWe got=%b exp=%b", tag, b, memWe, ~isLoad); end
      total++; if (memAddr !== addr) begin bad++; $display("FAIL %s busy%0d memAddr got=%h exp=%h", tag, b, memAddr, addr); end
      total++; if (memWdata !== wdata) begin bad++; $display("FAIL %s busy%0d memWdata got=%h exp=%h", tag, b, memWdata, wdata); end
      total++; if (regWriteW !== 1'b0) begin bad++; $display("FAIL %s busy%0d regWriteW got=%b exp=0", tag, b, regWriteW); end
      total++; if (memToRegW !== 1'b0) begin bad++; $display("FAIL %s busy%0d memToRegW got=%b exp=0", tag, b, memToRegW); end
      total++; if (busErr !== 1'b0) begin bad++; $display("FAIL %s busy%0d busErr got=%b exp=0", tag, b, busErr); end
      total++; if (dmOutW !== expDm) begin bad++; $display("FAIL %s busy%0d dmOutW got=%h exp=%h", tag, b, dmOutW, expDm); end
      @(posedge clk); #1;
    end
    if (timedOut) expDm = '0;
    else if (isLoad) expDm = rdata;
    memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s done stall got=%b exp=0", tag, stall); end
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL %s done memReq got=%b exp=0", tag, memReq); end
    total++; if (busErr !== timedOut) begin bad++; $display("FAIL %s done busErr got=%b exp=%b", tag, busErr, timedOut); end
    total++; if (dmOutW !== expDm) begin bad++; $display("FAIL %s done dmOutW got=%h exp=%h", tag, dmOutW, expDm); end
    total++; if (regWriteW !== regw) begin bad++; $display("FAIL %s done regWriteW got=%b exp=%b", tag, regWriteW, regw); end
    total++; if (memToRegW !== isLoad) begin bad++; $display("FAIL %s done memToRegW got=%b exp=%b", tag, memToRegW, isLoad); end
    total++; if (writeRegW !== wreg) begin bad++; $display("FAIL %s done writeRegW got=%h exp=%h", tag, writeRegW, wreg); end
    @(posedge clk); #1;
    memAck = 1'b0;
  endtask

  // Non-memory cycles with spurious acks: nothing may stall, request or disturb data.
  task automatic test_alu(input int n, input string tag);
    logic expRw;
    for (int i = 0; i < n; i++) begin
      validM = 1'($urandom_range(0, 1)); regWriteM = 1'($urandom_range(0, 1));
      memWriteM = 1'b0; memToRegM = validM ? 1'b0 : 1'($urandom_range(0, 1));
      aluOutM = $urandom; writeDataM = $urandom; writeRegM = 5'($urandom);
      memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
      expRw = regWriteM & validM;
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s%0d stall got=%b exp=0", tag, i, stall); end
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL %s%0d memReq got=%b exp=0", tag, i, memReq); end
      total++; if (busErr !== 1'b0) begin bad++; $display("FAIL %s%0d busErr got=%b exp=0", tag, i, busErr); end
      total++; if (regWriteW !== expRw) begin bad++; $display("FAIL %s%0d regWriteW got=%b exp=%b", tag, i, regWriteW, expRw); end
      total++; if (memToRegW !== 1'b0) begin bad++; $display("FAIL %s%0d memToRegW got=%b exp=0", tag, i, memToRegW); end
      total++; if (aluOutW !== aluOutM) begin bad++; $display("FAIL %s%0d aluOutW got=%h exp=%h", tag, i, aluOutW, aluOutM); end
      total++; if (writeRegW !== writeRegM) begin bad++; $display("FAIL %s%0d writeRegW got=%h exp=%h", tag, i, writeRegW, writeRegM); end
      total++; if (dmOutW !== expDm) begin bad++; $display("FAIL %s%0d dmOutW got=%h exp=%h", tag, i, dmOutW, expDm); end
      @(posedge clk); #1;
    end
    memAck = 1'b0;
  endtask

  task automatic test_reset_busy();
    validM = 1'b1; regWriteM = 1'b1; memToRegM = 1'b1; memWriteM = 1'b0;
    aluOutM = 32'h300; writeDataM = 32'h0; writeRegM = 5'd7; memAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (memReq !== 1'b1) begin bad++; $display("FAIL rstbusy pre memReq got=%b exp=1", memReq); end
    #2 rstN = 1'b0;
    #1;
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rstbusy memReq got=%b exp=0", memReq); end
    total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL rstbusy memAddr got=%h exp=0", memAddr); end
    total++; if (dmOutW !== 32'h0) begin bad++; $display("FAIL rstbusy dmOutW got=%h exp=0", dmOutW); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstbusy stall got=%b exp=1", stall); end
    @(posedge clk); #1;
    rstN = 1'b1;
    expDm = '0;
    run_op(1'b1, 32'h300, 32'h0, 5'd7, 1'b1, 2, 32'h5A5A_1234, "rstbusy_reissue");
  endtask

  task automatic test_back_to_back(input int n);
    for (int i = 0; i < n; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(1, TIMEOUT + 2)), $urandom, "b2b");
      if ($urandom_range(0, 3) == 0) test_alu(1, "b2b_alu");
    end
  endtask

  initial begin
    test_reset();
    run_op(1'b1, 32'h100, 32'h0, 5'd3, 1'b1, 1, 32'hCAFE_F00D, "load");
    run_op(1'b0, 32'h200, 32'h1234_5678, 5'd0, 1'b0, 3, 32'hDEAD_BEEF, "store");
    test_alu(5, "alu");
    run_op(1'b1, 32'h400, 32'h0, 5'd9, 1'b1, TIMEOUT + 1, 32'h1111_2222, "timeout");
    run_op(1'b1, 32'h500, 32'h0, 5'd4, 1'b1, TIMEOUT, 32'h7777_8888, "ack_at_limit");
    test_alu(4, "spurious");
    test_reset_busy();
    test_back_to_back(25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
